// File: rtl/ctrl_seq_unit_pkg.sv
// Shared opcodes, sequencer states and instruction field offsets.
// Field offsets are LSB positions within {op,dc,s1c,s2c,dst,s1,s2}.
package ctrl_seq_pkg;

  localparam int OP_NOP  = 0;
  localparam int OP_JMP  = 1;
  localparam int OP_JZ   = 2;
  localparam int OP_JNZ  = 3;
  localparam int OP_CALL = 4;
  localparam int OP_RET  = 5;
  localparam int OP_HALT = 6;
  localparam int OP_PUSH = 7;
  localparam int OP_POP  = 8;
  localparam int OP_ALU  = 16;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT,
    FAULT
  } state_t;

  function automatic int src1_lsb(int vw);
    return vw;
  endfunction

  function automatic int dst_lsb(int vw);
    return 2 * vw;
  endfunction

  function automatic int s2c_lsb(int vw);
    return 3 * vw;
  endfunction

  function automatic int s1c_lsb(int vw);
    return 3 * vw + 2;
  endfunction

  function automatic int dc_lsb(int vw);
    return 3 * vw + 4;
  endfunction

  function automatic int opc_lsb(int vw);
    return 3 * vw + 6;
  endfunction

  function automatic int instr_width(int ow, int vw);
    return ow + 6 + 3 * vw;
  endfunction

endpackage

// File: rtl/ctrl_seq_unit_if.sv
// Fetch bus between sequencer (master) and program memory (slave).
// pc/fetch_req go to memory; instr/instr_valid come back.
interface ctrl_seq_unit_if
  import ctrl_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = instr_width(6, 8)
);
  logic [PC_WIDTH-1:0]    pc;
  logic                   fetch_req;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;

  modport master (
    output pc,
    output fetch_req,
    input  instr,
    input  instr_valid
  );

  modport slave (
    input  pc,
    input  fetch_req,
    output instr,
    output instr_valid
  );
endinterface

// File: rtl/ctrl_seq_unit_ras.sv
// Return-address LIFO: push/pop/full/empty from an occupancy count.
// dout is the current top entry (combinational).
module ret_addr_stack #(
  parameter int PC_WIDTH  = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_en,
  input  logic                pop_en,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] dout,
  output logic                full,
  output logic                empty
);
  localparam int AW = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [AW:0]         r_cnt;
  logic [AW-1:0]       w_wr_idx;
  logic [AW-1:0]       w_top_idx;

  assign w_wr_idx  = r_cnt[AW-1:0];
  assign w_top_idx = w_wr_idx - AW'(1);
  // Depth is a power of two, so count==DEPTH is exactly the MSB.
  assign full      = r_cnt[AW];
  assign empty     = (r_cnt == '0);
  assign dout      = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (push_en && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (pop_en && !empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end
endmodule

// File: rtl/ctrl_seq_unit.sv
// Fetch/decode/PC sequencer with branches, CALL/RET, HALT, fault.
// Ports: clk, rst, fbus (fetch master), zero_flag, decoded outputs.
module ctrl_seq_unit
  import ctrl_seq_pkg::*;
#(
  parameter  int OPCODE_WIDTH = 6,
  parameter  int VALUE_WIDTH  = 8,
  parameter  int PC_WIDTH     = 8,
  parameter  int RAS_DEPTH    = 8,
  localparam int INSTR_WIDTH  = OPCODE_WIDTH + 6 + 3 * VALUE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  ctrl_seq_unit_if.master         fbus,
  input  logic                    zero_flag,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [VALUE_WIDTH-1:0]  source1,
  output logic [VALUE_WIDTH-1:0]  source2,
  output logic [VALUE_WIDTH-1:0]  destination,
  output logic [1:0]              source1_choice,
  output logic [1:0]              source2_choice,
  output logic [1:0]              destination_choice,
  output logic                    exec_valid,
  output logic                    push,
  output logic                    pop,
  output logic                    halted,
  output logic                    fault
);
  localparam int S1_LSB  = src1_lsb(VALUE_WIDTH);
  localparam int DST_LSB = dst_lsb(VALUE_WIDTH);
  localparam int S2C_LSB = s2c_lsb(VALUE_WIDTH);
  localparam int S1C_LSB = s1c_lsb(VALUE_WIDTH);
  localparam int DC_LSB  = dc_lsb(VALUE_WIDTH);
  localparam int OPC_LSB = opc_lsb(VALUE_WIDTH);

  typedef logic [OPCODE_WIDTH-1:0] opc_t;

  state_t             r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic               r_fetch_req;
  logic               r_exec_valid;
  logic               r_push;
  logic               r_pop;
  logic               r_halted;
  logic               r_fault;
  opc_t               r_op;
  logic [VALUE_WIDTH-1:0] r_src1;
  logic [VALUE_WIDTH-1:0] r_src2;
  logic [VALUE_WIDTH-1:0] r_dst;
  logic [1:0]         r_s1c;
  logic [1:0]         r_s2c;
  logic [1:0]         r_dc;

  opc_t                w_op_in;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_tgt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic w_ras_full;
  logic w_ras_empty;
  logic w_in_exec;
  logic w_is_jmp;
  logic w_is_jz;
  logic w_is_jnz;
  logic w_is_call;
  logic w_is_ret;
  logic w_is_halt;
  logic w_ovf;
  logic w_unf;
  logic w_ras_push;
  logic w_ras_pop;

  assign w_op_in   = fbus.instr[OPC_LSB +: OPCODE_WIDTH];
  assign w_in_exec = (r_state == EXEC);
  assign w_is_jmp  = (r_op == opc_t'(OP_JMP));
  assign w_is_jz   = (r_op == opc_t'(OP_JZ));
  assign w_is_jnz  = (r_op == opc_t'(OP_JNZ));
  assign w_is_call = (r_op == opc_t'(OP_CALL));
  assign w_is_ret  = (r_op == opc_t'(OP_RET));
  assign w_is_halt = (r_op == opc_t'(OP_HALT));

  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_tgt    = PC_WIDTH'({r_src1, r_dst});
  assign w_ovf    = w_is_call && w_ras_full;
  assign w_unf    = w_is_ret && w_ras_empty;

  // Strobes only while executing, so reset mid-EXEC commits nothing.
  assign w_ras_push = w_in_exec && w_is_call && !w_ras_full;
  assign w_ras_pop  = w_in_exec && w_is_ret && !w_ras_empty;

  always_comb begin
    w_pc_nxt = w_pc_inc;
    unique case (1'b1)
      w_is_jmp:  w_pc_nxt = w_tgt;
      w_is_jz:   if (zero_flag) w_pc_nxt = w_tgt;
      w_is_jnz:  if (!zero_flag) w_pc_nxt = w_tgt;
      w_is_call: w_pc_nxt = w_tgt;
      w_is_ret:  w_pc_nxt = w_ras_top;
      w_is_halt: w_pc_nxt = r_pc;
      default:   w_pc_nxt = w_pc_inc;
    endcase
  end

  ret_addr_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_en (w_ras_push),
    .pop_en  (w_ras_pop),
    .din     (w_pc_inc),
    .dout    (w_ras_top),
    .full    (w_ras_full),
    .empty   (w_ras_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= '0;
      r_fetch_req  <= 1'b1;
      r_exec_valid <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_op         <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_dst        <= '0;
      r_s1c        <= '0;
      r_s2c        <= '0;
      r_dc         <= '0;
    end else begin
      r_exec_valid <= 1'b0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      unique case (r_state)
        FETCH: begin
          if (fbus.instr_valid) begin
            r_state      <= EXEC;
            r_fetch_req  <= 1'b0;
            r_exec_valid <= 1'b1;
            r_push <= (w_op_in == opc_t'(OP_PUSH));
            r_pop  <= (w_op_in == opc_t'(OP_POP));
            r_op   <= w_op_in;
            r_src2 <= fbus.instr[0 +: VALUE_WIDTH];
            r_src1 <= fbus.instr[S1_LSB +: VALUE_WIDTH];
            r_dst  <= fbus.instr[DST_LSB +: VALUE_WIDTH];
            r_s2c  <= fbus.instr[S2C_LSB +: 2];
            r_s1c  <= fbus.instr[S1C_LSB +: 2];
            r_dc   <= fbus.instr[DC_LSB +: 2];
          end
        end
        EXEC: begin
          if (w_ovf || w_unf) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (w_is_halt) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_state     <= FETCH;
            r_fetch_req <= 1'b1;
            r_pc        <= w_pc_nxt;
          end
        end
        HALT, FAULT: ;
      endcase
    end
  end

  assign fbus.pc            = r_pc;
  assign fbus.fetch_req     = r_fetch_req;
  assign op_code            = r_op;
  assign source1            = r_src1;
  assign source2            = r_src2;
  assign destination        = r_dst;
  assign source1_choice     = r_s1c;
  assign source2_choice     = r_s2c;
  assign destination_choice = r_dc;
  assign exec_valid         = r_exec_valid;
  assign push               = r_push;
  assign pop                = r_pop;
  assign halted             = r_halted;
  assign fault              = r_fault;
endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
- Parametrised successor to the processor control module. Fetches instruction words from external program memory, decodes them into ALU/operand-select controls, and sequences the PC.
- Adds a valid/ready fetch handshake, conditional branches on zero_flag, CALL/RET through an internal return-address stack (RAS), HALT, and a sticky fault state.
- Sits between program memory and the datapath (ALU, register file, data stack).

Parameters:
- OPCODE_WIDTH, 6, opcode field width.
- VALUE_WIDTH, 8, width of each operand/address field (source1, source2, destination).
- PC_WIDTH, 8, program counter width.
- RAS_DEPTH, 8, return-address stack entries (power of 2, >=2).
- INSTR_WIDTH, OPCODE_WIDTH+6+3*VALUE_WIDTH, derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  INSTR_WIDTH  fetched word {opcode, dst_choice[1:0], src1_choice[1:0], src2_choice[1:0], destination, source1, source2}, MSB first.
- instr_valid  in  1  memory returns instr for the current pc.
- zero_flag  in  1  ALU zero flag from the previous executed instruction.
- pc  out  PC_WIDTH  fetch address.
- fetch_req  out  1  fetch request.
- op_code  out  OPCODE_WIDTH  decoded opcode.
- source1, source2, destination  out  VALUE_WIDTH each  operand fields.
- source1_choice, source2_choice, destination_choice  out  2 each  operand-select fields.
- exec_valid  out  1  decoded outputs valid this cycle.
- push, pop  out  1 each  data-stack strobes.
- halted  out  1  HALT executed.
- fault  out  1  RAS overflow or underflow.

Behaviour:
- Reset (async, any state):
  - pc=0; state=FETCH.
  - All decoded outputs, strobes, halted and fault = 0.
  - RAS pointer = 0 (empty).
- FETCH state:
  - fetch_req=1; pc held stable.
  - Each clk edge with instr_valid=1 registers instr and moves to EXEC.
  - While instr_valid=0, wait indefinitely with outputs unchanged.
- EXEC state (exactly one cycle):
  - exec_valid=1; decoded fields are registered copies of instr. op_code/operands/choices hold their last value outside EXEC.
  - push=1 only for OP_PUSH; pop=1 only for OP_POP. Both 0 in every other state.
  - Next state is FETCH unless HALT or a fault occurs.
- Branch/jump target: tgt = low PC_WIDTH bits of {source1, destination}.
- Next pc at the end of EXEC:
  - OP_JMP: tgt.
  - OP_JZ: tgt if zero_flag=1, else pc+1.
  - OP_JNZ: tgt if zero_flag=0, else pc+1.
  - zero_flag is sampled on the clk edge that ends EXEC.
  - OP_CALL: push pc+1 to the RAS, then pc=tgt.
  - OP_RET: pop the RAS into pc.
  - OP_HALT: go to HALT; pc unchanged.
  - All other opcodes (ALU, NOP, PUSH, POP): pc+1, wrapping modulo 2^PC_WIDTH.
- Control opcodes (JMP, JZ, JNZ, CALL, RET, HALT, NOP) still pulse exec_valid. The datapath ignores them by opcode.
- HALT state: halted=1; fetch_req=0. Leaves only by rst.
- FAULT state:
  - Entered on CALL with a full RAS (RAS_DEPTH entries) or RET with an empty RAS.
  - fault=1; fetch_req=0; RAS and pc unchanged. Sticky until rst.
- RAS: RAS_DEPTH-deep LIFO with a count of 0..RAS_DEPTH. Full and empty are derived from the count. No wrap-around: overflow faults instead of overwriting.
- instr_valid is ignored outside FETCH.
- rst asserted mid-FETCH or mid-EXEC aborts the instruction; no push/pop strobe or RAS change is committed.

Decomposition:
- Package ctrl_seq_pkg holds:
  - opcode localparams: OP_NOP=0, OP_JMP=1, OP_JZ=2, OP_JNZ=3, OP_CALL=4, OP_RET=5, OP_HALT=6, OP_PUSH=7, OP_POP=8; ALU opcodes are 16 and above.
  - state enum {FETCH, EXEC, HALT, FAULT}.
  - instruction field offset functions.
- Sub-module ret_addr_stack(clk, rst, push_en, pop_en, din, dout, full, empty), parametrised by PC_WIDTH and RAS_DEPTH. dout is combinational from the top entry.

Test Plan:
1. Reset then ALU instr at pc 0, instr_valid after 2 wait cycles -> fetch_req held 3 cycles; one exec_valid pulse; pc=1.
2. JZ tgt=0x20 with zero_flag=1, then JZ with zero_flag=0 -> pc=0x20, then pc=0x21.
3. JNZ tgt=0x40 with zero_flag=0 -> pc=0x40; with zero_flag=1 -> pc+1.
4. CALL 0x10 at pc 5, then RET -> pc=0x10, then pc=6; RAS empty afterwards.
5. RAS_DEPTH+1 nested CALLs -> fault=1 on the 9th call; fetch_req=0. RET on empty after reset -> fault=1.
6. PUSH, POP, then HALT -> push and pop each a 1-cycle pulse during EXEC; halted=1, fetch_req=0. Assert rst mid-EXEC -> all outputs 0, pc=0.
